// File: rtl/dac_dual_writer.sv
// Serial writer for a dual-channel 12-bit DAC: shifts frame A and frame B MSB first,
// then strobes nLDAC so both channels update together. All pin outputs are registered.
module dac_dual_writer #(
   parameter int CLK_DIV   = 1,
   parameter int SYNC_HIGH = 2,
   parameter int LDAC_LOW  = 2
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [11:0] InA,
   input  logic [11:0] InB,
   input  logic        Valid,
   output logic        Ready,
   output logic        nSync,
   output logic        SClk,
   output logic        SData,
   output logic        nLDAC
);

   localparam int DW = $clog2(CLK_DIV + 1);
   localparam int WMAX = (SYNC_HIGH > LDAC_LOW) ? SYNC_HIGH : LDAC_LOW;
   localparam int WW = $clog2(WMAX + 1);
   localparam logic [DW-1:0] DIV_END = DW'(CLK_DIV - 1);
   localparam logic [WW-1:0] GAP_END = WW'(SYNC_HIGH - 1);
   localparam logic [WW-1:0] LD_END  = WW'(LDAC_LOW - 1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SHIFT_HI = 3'd1,
      SHIFT_LO = 3'd2,
      GAP      = 3'd3,
      LDAC     = 3'd4
   } state_t;

   state_t      state;
   logic [15:0] shreg;
   logic [11:0] smpl_b;
   logic        in_frame_b;
   logic [3:0]  bitcnt;
   logic [DW-1:0] divcnt;
   logic [WW-1:0] wcnt;

   // Address in [15:14] (A=00, B=01), normal mode in [13:12]
   logic [15:0] frame_a, frame_b;
   assign frame_a = {4'b0000, InA};
   assign frame_b = {4'b0100, smpl_b};

   logic bad_state;
   assign bad_state = !(state inside {IDLE, SHIFT_HI, SHIFT_LO, GAP, LDAC});

   always_ff @(posedge Clk) begin
      if (Reset || bad_state) begin
         state      <= IDLE;
         Ready      <= 1'b1;
         nSync      <= 1'b1;
         SClk       <= 1'b1;
         SData      <= 1'b0;
         nLDAC      <= 1'b1;
         shreg      <= '0;
         smpl_b     <= '0;
         in_frame_b <= 1'b0;
         bitcnt     <= '0;
         divcnt     <= '0;
         wcnt       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (Valid && Ready) begin
                  shreg      <= frame_a;
                  smpl_b     <= InB;
                  in_frame_b <= 1'b0;
                  bitcnt     <= 4'd15;
                  divcnt     <= '0;
                  Ready      <= 1'b0;
                  nSync      <= 1'b0;
                  SData      <= frame_a[15];
                  state      <= SHIFT_HI;
               end
            end
            SHIFT_HI: begin
               if (divcnt == DIV_END) begin
                  divcnt <= '0;
                  SClk   <= 1'b0;
                  state  <= SHIFT_LO;
               end else begin
                  divcnt <= divcnt + 1'b1;
               end
            end
            SHIFT_LO: begin
               if (divcnt == DIV_END) begin
                  divcnt <= '0;
                  SClk   <= 1'b1;
                  if (bitcnt == 4'd0) begin
                     // nSync rises together with SClk so it only moves while SClk is high
                     nSync <= 1'b1;
                     SData <= 1'b0;
                     wcnt  <= '0;
                     if (in_frame_b) begin
                        nLDAC <= 1'b0;
                        state <= LDAC;
                     end else begin
                        state <= GAP;
                     end
                  end else begin
                     bitcnt <= bitcnt - 4'd1;
                     SData  <= shreg[14];
                     shreg  <= {shreg[14:0], 1'b0};
                     state  <= SHIFT_HI;
                  end
               end else begin
                  divcnt <= divcnt + 1'b1;
               end
            end
            GAP: begin
               if (wcnt == GAP_END) begin
                  wcnt       <= '0;
                  nSync      <= 1'b0;
                  shreg      <= frame_b;
                  SData      <= frame_b[15];
                  in_frame_b <= 1'b1;
                  bitcnt     <= 4'd15;
                  divcnt     <= '0;
                  state      <= SHIFT_HI;
               end else begin
                  wcnt <= wcnt + 1'b1;
               end
            end
            LDAC: begin
               if (wcnt == LD_END) begin
                  wcnt  <= '0;
                  nLDAC <= 1'b1;
                  Ready <= 1'b1;
                  state <= IDLE;
               end else begin
                  wcnt <= wcnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dac_dual_writer.sv
// Directed bench for dac_dual_writer: default-parameter instance plus a CLK_DIV=3 instance,
// pin monitors rebuild frames from SClk falling edges.
module tb_dac_dual_writer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [11:0] ina = '0, inb = '0, ina3 = '0, inb3 = '0;
   logic        vld = 1'b0, vld3 = 1'b0;
   logic        rdy, nsync, sclk, sdata, nldac;
   logic        rdy3, nsync3, sclk3, sdata3, nldac3;

   int checks = 0;
   int failures = 0;

   dac_dual_writer dut (
      .Clk(clk), .Reset(rst), .InA(ina), .InB(inb), .Valid(vld),
      .Ready(rdy), .nSync(nsync), .SClk(sclk), .SData(sdata), .nLDAC(nldac)
   );

   dac_dual_writer #(.CLK_DIV(3), .SYNC_HIGH(2), .LDAC_LOW(2)) dut3 (
      .Clk(clk), .Reset(rst), .InA(ina3), .InB(inb3), .Valid(vld3),
      .Ready(rdy3), .nSync(nsync3), .SClk(sclk3), .SData(sdata3), .nLDAC(nldac3)
   );

   // Pin monitor for the default instance
   logic [15:0] sh0 = '0;
   logic [15:0] frames0[$];
   int nb0 = 0, gap_run0 = 0, last_gap0 = 0, ld_run0 = 0, last_ld0 = 0, ldac_pulses0 = 0;
   int rl_run0 = 0, last_rl0 = 0, rh_run0 = 0, last_rh0 = 0, viol0 = 0;
   logic p_sclk0 = 1'b1, p_nsync0 = 1'b1, p_nldac0 = 1'b1, p_rdy0 = 1'b1;

   always @(negedge clk) begin
      if (!nsync && p_sclk0 && !sclk) begin
         sh0 = {sh0[14:0], sdata};
         nb0++;
      end
      if (!p_nsync0 && nsync) begin
         if (nb0 == 16) frames0.push_back(sh0);
         nb0 = 0;
      end
      if (nsync) gap_run0++;
      else begin
         if (p_nsync0) last_gap0 = gap_run0;
         gap_run0 = 0;
      end
      if (!nldac) begin
         if (p_nldac0) ldac_pulses0++;
         ld_run0++;
      end else begin
         if (!p_nldac0) last_ld0 = ld_run0;
         ld_run0 = 0;
      end
      if (!rdy) begin
         if (p_rdy0) last_rh0 = rh_run0;
         rh_run0 = 0;
         rl_run0++;
      end else begin
         if (!p_rdy0) last_rl0 = rl_run0;
         rl_run0 = 0;
         rh_run0++;
      end
      if (!nldac && !nsync) viol0++;
      if ((nsync !== p_nsync0) && !sclk) viol0++;
      p_sclk0 = sclk; p_nsync0 = nsync; p_nldac0 = nldac; p_rdy0 = rdy;
   end

   // Pin monitor for the CLK_DIV=3 instance
   logic [15:0] sh3 = '0;
   logic [15:0] frames3[$];
   int nb3 = 0, rl_run3 = 0, last_rl3 = 0, hp_run3 = 0, hp_min3 = 1000, hp_max3 = 0, viol3 = 0;
   logic p_sclk3 = 1'b1, p_nsync3 = 1'b1, p_rdy3 = 1'b1;

   always @(negedge clk) begin
      if (!nsync3 && p_sclk3 && !sclk3) begin
         sh3 = {sh3[14:0], sdata3};
         nb3++;
      end
      if (!p_nsync3 && nsync3) begin
         if (nb3 == 16) frames3.push_back(sh3);
         nb3 = 0;
      end
      if (!nsync3) begin
         if (p_nsync3) hp_run3 = 1;
         else if (sclk3 !== p_sclk3) begin
            if (hp_run3 < hp_min3) hp_min3 = hp_run3;
            if (hp_run3 > hp_max3) hp_max3 = hp_run3;
            hp_run3 = 1;
         end else hp_run3++;
      end
      if (!rdy3) rl_run3++;
      else begin
         if (!p_rdy3) last_rl3 = rl_run3;
         rl_run3 = 0;
      end
      if (!nldac3 && !nsync3) viol3++;
      if ((nsync3 !== p_nsync3) && !sclk3) viol3++;
      p_sclk3 = sclk3; p_nsync3 = nsync3; p_rdy3 = rdy3;
   end

   task automatic wait_idle0(input int lim, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < lim; i++) begin
         @(negedge clk);
         if (rdy) begin ok = 1'b1; break; end
      end
   endtask

   task automatic wait_idle3(input int lim, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < lim; i++) begin
         @(negedge clk);
         if (rdy3) begin ok = 1'b1; break; end
      end
   endtask

   // Called at a falling edge with Ready high; returns one cycle later
   task automatic send0(input logic [11:0] a, input logic [11:0] b);
      ina = a; inb = b; vld = 1'b1;
      @(negedge clk);
      vld = 1'b0;
   endtask

   task automatic send3(input logic [11:0] a, input logic [11:0] b);
      ina3 = a; inb3 = b; vld3 = 1'b1;
      @(negedge clk);
      vld3 = 1'b0;
   endtask

   task automatic chk_frame(input string nm, input int idx, input logic [15:0] exp);
      checks++;
      if (idx >= frames0.size()) begin
         failures++;
         $display("FAIL %s: frame %0d missing, only %0d captured, required 0x%04h", nm, idx, frames0.size(), exp);
      end else if (frames0[idx] !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%04h required 0x%04h", nm, frames0[idx], exp);
      end
   endtask

   task automatic chk_int(input string nm, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d required %0d", nm, got, exp);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checks++;
         if ({rdy, nsync, sclk, nldac, sdata} !== 5'b11110) begin
            failures++;
            $display("FAIL reset_idle: cycle %0d pins %b required 11110", i, {rdy, nsync, sclk, nldac, sdata});
         end
         checks++;
         if ({rdy3, nsync3, sclk3, nldac3, sdata3} !== 5'b11110) begin
            failures++;
            $display("FAIL reset_idle3: cycle %0d pins %b required 11110", i, {rdy3, nsync3, sclk3, nldac3, sdata3});
         end
      end
   endtask

   task automatic test_basic();
      int n, p;
      bit ok;
      n = frames0.size(); p = ldac_pulses0;
      send0(12'hABC, 12'h123);
      wait_idle0(200, ok);
      chk_int("basic_done", int'(ok), 1);
      @(negedge clk);
      chk_frame("basic_frameA", n, 16'h0ABC);
      chk_frame("basic_frameB", n + 1, 16'h4123);
      chk_int("basic_frames", frames0.size() - n, 2);
      chk_int("basic_gap", last_gap0, 2);
      chk_int("basic_ldac_len", last_ld0, 2);
      chk_int("basic_ldac_pulses", ldac_pulses0 - p, 1);
      chk_int("basic_ready_low", last_rl0, 68);
   endtask

   task automatic test_clkdiv3();
      int n;
      bit ok;
      n = frames3.size();
      send3(12'hFFF, 12'h000);
      wait_idle3(400, ok);
      chk_int("div3_done", int'(ok), 1);
      @(negedge clk);
      chk_int("div3_frames", frames3.size() - n, 2);
      if (frames3.size() >= n + 2) begin
         chk_int("div3_frameA", int'(frames3[n]), 16'h0FFF);
         chk_int("div3_frameB", int'(frames3[n + 1]), 16'h4000);
      end
      chk_int("div3_ready_low", last_rl3, 196);
      chk_int("div3_half_min", hp_min3, 3);
      chk_int("div3_half_max", hp_max3, 3);
   endtask

   task automatic test_back_to_back();
      int n;
      bit ok;
      n = frames0.size();
      ina = 12'h001; inb = 12'h800; vld = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (!rdy) begin ok = 1'b1; break; end
      end
      chk_int("b2b_accept1", int'(ok), 1);
      ina = 12'h7FF; inb = 12'h555;
      wait_idle0(200, ok);
      chk_int("b2b_ready1", int'(ok), 1);
      ok = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (!rdy) begin ok = 1'b1; break; end
      end
      chk_int("b2b_accept2", int'(ok), 1);
      ina = 12'hEEE; inb = 12'hEEE; vld = 1'b0;
      wait_idle0(200, ok);
      chk_int("b2b_done", int'(ok), 1);
      @(negedge clk);
      chk_int("b2b_ready_gap", last_rh0, 1);
      chk_frame("b2b_frameA1", n, 16'h0001);
      chk_frame("b2b_frameB1", n + 1, 16'h4800);
      chk_frame("b2b_frameA2", n + 2, 16'h07FF);
      chk_frame("b2b_frameB2", n + 3, 16'h4555);
   endtask

   task automatic test_reset_mid();
      int n, p;
      bit ok;
      n = frames0.size(); p = ldac_pulses0;
      send0(12'h111, 12'h222);
      // 32 cycles frame A, 2 cycles gap, then 5 bits of frame B
      repeat (44) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({rdy, nsync, sclk, nldac, sdata} !== 5'b11110) begin
         failures++;
         $display("FAIL rstmid_idle: pins %b required 11110", {rdy, nsync, sclk, nldac, sdata});
      end
      rst = 1'b0;
      repeat (10) @(negedge clk);
      chk_int("rstmid_no_ldac", ldac_pulses0 - p, 0);
      chk_int("rstmid_frames", frames0.size() - n, 1);
      send0(12'h321, 12'h654);
      wait_idle0(200, ok);
      chk_int("rstmid_done", int'(ok), 1);
      @(negedge clk);
      chk_frame("rstmid_frameA", n + 1, 16'h0321);
      chk_frame("rstmid_frameB", n + 2, 16'h4654);
      chk_int("rstmid_ldac_after", ldac_pulses0 - p, 1);
   endtask

   task automatic test_random();
      logic [11:0] ea[500];
      logic [11:0] eb[500];
      int n;
      bit ok;
      n = frames0.size();
      for (int i = 0; i < 500; i++) begin
         ea[i] = 12'($urandom_range(0, 4095));
         eb[i] = 12'($urandom_range(0, 4095));
         send0(ea[i], eb[i]);
         wait_idle0(200, ok);
         if (!ok) begin
            checks++; failures++;
            $display("FAIL rand_timeout: transaction %0d did not complete", i);
            break;
         end
      end
      @(negedge clk);
      chk_int("rand_frames", frames0.size() - n, 1000);
      for (int i = 0; i < 500; i++) begin
         chk_frame("rand_frameA", n + 2 * i, {4'b0000, ea[i]});
         chk_frame("rand_frameB", n + 2 * i + 1, {4'b0100, eb[i]});
      end
   endtask

   task automatic test_pin_rules();
      chk_int("rules_dut", viol0, 0);
      chk_int("rules_dut3", viol3, 0);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_clkdiv3();
      test_back_to_back();
      test_reset_mid();
      test_random();
      test_pin_rules();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
